// File: rtl/reg_file_write_arbiter.sv
// Two-port round-robin write arbiter in front of a register file, with a
// built-in sequencer that zeroes every register on request.
module reg_file_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [AW-1:0] rf_write_reg,
  output logic [DW-1:0] rf_write_data,
  output logic          rf_reg_write
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST_REG = '1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rr;
  logic [AW-1:0] r_cnt;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [AW-1:0] r_wr_reg;
  logic [DW-1:0] r_wr_data;
  logic          r_wr_en;

  // Grants are only offered in IDLE and are suppressed by a pending clear.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_start) begin
          w_state_nxt = CLEAR;
        end else if (req0 && (!req1 || !r_rr)) begin
          w_gnt0 = 1'b1;
        end else if (req1) begin
          w_gnt1 = 1'b1;
        end
      end
      CLEAR: begin
        if (r_cnt == LAST_REG) w_state_nxt = IDLE;
      end
    endcase
    if (reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // A grant is only issued alongside its request, so a grant marks a transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_rr      <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_cnt   <= '0;
            r_wr_en <= 1'b0;
          end else if (w_gnt0) begin
            r_wr_en   <= 1'b1;
            r_wr_reg  <= addr0;
            r_wr_data <= data0;
            r_rr      <= 1'b1;
          end else if (w_gnt1) begin
            r_wr_en   <= 1'b1;
            r_wr_reg  <= addr1;
            r_wr_data <= data1;
            r_rr      <= 1'b0;
          end else begin
            r_wr_en <= 1'b0;
          end
        end
        CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_reg  <= r_cnt;
          r_wr_data <= '0;
          r_cnt     <= r_cnt + AW'(1);
        end
      endcase
    end
  end

  assign gnt0          = w_gnt0;
  assign gnt1          = w_gnt1;
  assign clr_busy      = (r_state == CLEAR);
  assign rf_write_reg  = r_wr_reg;
  assign rf_write_data = r_wr_data;
  assign rf_reg_write  = r_wr_en;

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Directed bench for reg_file_write_arbiter; a register file array is fed
// from the rf_* outputs so register contents can be read back.
module tb_reg_file_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREGS = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          clr_start;
  logic          clr_busy;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_write_data;
  logic          rf_reg_write;

  logic [DW-1:0] mem [NREGS];
  int            nwr = 0;
  int            total = 0;
  int            bad = 0;
  int            nwr0;
  int            busy_cnt;

  reg_file_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clock(clock), .reset(reset), .clr_start(clr_start), .clr_busy(clr_busy),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_reg_write(rf_reg_write)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rf_reg_write) begin
      mem[rf_write_reg] <= rf_write_data;
      nwr <= nwr + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic preload();
    req0 = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      addr0 = AW'(i);
      data0 = 32'h100 + 32'(i);
      cyc();
    end
    req0 = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1; clr_start = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;

    // Reset state and grant suppression under reset
    @(negedge clock);
    chk("gnt0_in_reset", 32'(gnt0), 32'd0);
    chk("gnt1_in_reset", 32'(gnt1), 32'd0);
    cyc();
    @(negedge clock);
    chk("rst_wr_en", 32'(rf_reg_write), 32'd0);
    chk("rst_wr_reg", 32'(rf_write_reg), 32'd0);
    chk("rst_wr_data", rf_write_data, 32'd0);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    cyc();

    // Contention: alternating grants starting at port 0
    reset = 1'b0;
    addr0 = 5'd3; data0 = 32'h33;
    addr1 = 5'd4; data1 = 32'h44;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("cont_gnt0", 32'(gnt0), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_gnt1", 32'(gnt1), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) chk("cont_reg", 32'(rf_write_reg), (k % 2 == 1) ? 32'd3 : 32'd4);
    end
    cyc();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clock);
    chk("cont_last_reg", 32'(rf_write_reg), 32'd4);
    chk("cont_last_data", rf_write_data, 32'h44);
    cyc();

    // Fill every register with a nonzero pattern via back-to-back writes
    preload();
    @(negedge clock);
    chk("preload_r0", mem[0], 32'h100);
    chk("preload_r31", mem[31], 32'h11f);
    cyc();

    // Single requester
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req0 = 1'b1; addr0 = 5'd5; data0 = 32'hA5A5A5A5;
    @(negedge clock);
    chk("single_gnt0", 32'(gnt0), 32'd1);
    chk("single_gnt1", 32'(gnt1), 32'd0);
    cyc();
    req0 = 1'b0;
    @(negedge clock);
    chk("single_wr_en", 32'(rf_reg_write), 32'd1);
    chk("single_wr_reg", 32'(rf_write_reg), 32'd5);
    chk("single_wr_data", rf_write_data, 32'hA5A5A5A5);
    cyc();
    @(negedge clock);
    chk("idle_wr_en", 32'(rf_reg_write), 32'd0);
    chk("idle_hold_reg", 32'(rf_write_reg), 32'd5);
    chk("idle_hold_data", rf_write_data, 32'hA5A5A5A5);
    chk("single_mem5", mem[5], 32'hA5A5A5A5);
    cyc();

    // Full clear; clr_start beats a simultaneous request
    clr_start = 1'b1; req0 = 1'b1; addr0 = 5'd2; data0 = 32'hDEAD;
    @(negedge clock);
    chk("clr_prio_gnt0", 32'(gnt0), 32'd0);
    cyc();
    clr_start = 1'b0; req0 = 1'b0;
    nwr0 = nwr;
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clock);
      chk("clr_busy_hi", 32'(clr_busy), 32'd1);
      chk("clr_wr_en", 32'(rf_reg_write), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        chk("clr_wr_reg", 32'(rf_write_reg), 32'(i - 1));
        chk("clr_wr_data", rf_write_data, 32'd0);
      end
    end
    @(negedge clock);
    chk("clr_busy_lo", 32'(clr_busy), 32'd0);
    chk("clr_last_reg", 32'(rf_write_reg), 32'd31);
    chk("clr_last_en", 32'(rf_reg_write), 32'd1);
    @(negedge clock);
    chk("clr_done_en", 32'(rf_reg_write), 32'd0);
    chk("clr_nwrites", 32'(nwr - nwr0), 32'd32);
    for (int i = 0; i < NREGS; i++) chk("clr_mem_zero", mem[i], 32'd0);
    cyc();

    // Clear with a request held throughout
    clr_start = 1'b1; req1 = 1'b1; addr1 = 5'd7; data1 = 32'd9;
    @(negedge clock);
    chk("pend_gnt1_start", 32'(gnt1), 32'd0);
    cyc();
    clr_start = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clock);
      chk("pend_gnt1_clear", 32'(gnt1), 32'd0);
    end
    @(negedge clock);
    chk("pend_busy_lo", 32'(clr_busy), 32'd0);
    chk("pend_gnt1_idle", 32'(gnt1), 32'd1);
    cyc();
    req1 = 1'b0;
    @(negedge clock);
    chk("pend_wr_reg", 32'(rf_write_reg), 32'd7);
    chk("pend_wr_data", rf_write_data, 32'd9);
    cyc();
    @(negedge clock);
    chk("pend_mem7", mem[7], 32'd9);
    cyc();

    // Reset in the middle of a clear (cnt = 10)
    preload();
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    @(negedge clock);
    chk("rstmid_reg9", 32'(rf_write_reg), 32'd9);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_wr_en", 32'(rf_reg_write), 32'd0);
    chk("rstmid_busy", 32'(clr_busy), 32'd0);
    chk("rstmid_wr_reg", 32'(rf_write_reg), 32'd0);
    cyc();
    @(negedge clock);
    chk("rstmid_mem9", mem[9], 32'd0);
    chk("rstmid_mem0", mem[0], 32'd0);
    for (int i = 10; i < NREGS; i++) chk("rstmid_mem_kept", mem[i], 32'h100 + 32'(i));
    cyc();

    // clr_start repeated mid-clear is ignored
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    nwr0 = nwr;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (clr_busy) busy_cnt++;
      if (i == 20) clr_start = 1'b1;
      if (i == 21) clr_start = 1'b0;
      if (i == 31) chk("restart_busy_31", 32'(clr_busy), 32'd1);
      if (i == 32) chk("restart_busy_32", 32'(clr_busy), 32'd0);
    end
    chk("restart_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("restart_nwrites", 32'(nwr - nwr0), 32'd32);
    chk("restart_mem20", mem[20], 32'd0);
    chk("restart_mem31", mem[31], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
